result_collector: RTL and testbench
===================================

// Module: result_collector
// PURPOSE
//  Sits between the execution-unit reservation stations (ALU, BU, FPU, UART, MEM) and the commit queue.
//  Buffers each unit's Result in a private FIFO and arbitrates round-robin.
//  Broadcasts at most one Result per cycle as complete_info, consumed by the commit queue and all RS wakeup logic.
//  The flash input empties the block on reset or branch mispredict.
// PARAMETERS
//  NUM_Q     5   number of producer ports (0=ALU,1=BU,2=FPU,3=UART,4=MEM)
//  DEPTH     4   entries per producer FIFO; power of 2, >=2
//  RESULT_W  41  Result width: [40:33] commit tag (w8), [32:1] data, [0] valid-dest flag
// PORTS
//  clock          in   1               rising-edge clock
//  reset          in   1               asynchronous, active-low reset
//  flash          in   1               synchronous flush (reset | mispredict), active-high
//  r_en           in   NUM_Q           producer i pushes r_data slice i this cycle
//  r_data         in   NUM_Q*RESULT_W  slice i = [i*RESULT_W +: RESULT_W]
//  r_full         out  NUM_Q           FIFO i full; producer i must not push
//  complete_en    out  1               complete_data valid this cycle (no backpressure)
//  complete_data  out  RESULT_W        broadcast Result
//  complete_src   out  $clog2(NUM_Q)   index of producer that supplied complete_data
//  overflow       out  1               sticky: a push arrived while r_full was high
// BEHAVIOUR
//  Reset (reset=0, async): all FIFOs empty; rr_last=NUM_Q-1; complete_en=0; complete_data=0;
//   complete_src=0; overflow=0; r_full=0. Nothing is captured while reset is low.
//  FIFO i: rd/wr pointers of $clog2(DEPTH)+1 bits; count = wr-rd, mod 2^(ptr width).
//   r_full[i] = (count==DEPTH); combinational from registered state only.
//  Push: r_en[i] & !r_full[i] writes slice i at the rising edge.
//   A push on a full FIFO is dropped, even if a pop occurs in the same cycle, and sets overflow.
//  Arbitration (cycle N): eligible = FIFOs with count>0 on registered state.
//   A push made in cycle N is not eligible before cycle N+1; there is no bypass.
//   Grant = first eligible index scanning rr_last+1, rr_last+2, ... modulo NUM_Q.
//   On grant g: pop FIFO g; rr_last<=g.
//   complete_data<=head g; complete_src<=g; complete_en<=1, all visible in cycle N+1.
//   No eligible FIFO: complete_en<=0; complete_data and complete_src hold their values.
//  Latency: a push in cycle N onto an idle block produces complete_en in cycle N+2.
//  Throughput: 1 Result/cycle total; each producer is served at least once every NUM_Q grants.
//  Simultaneous push and pop on the same FIFO: count unchanged; a non-full FIFO accepts the push.
//  Flash (sync, highest priority after reset): at the edge, all pointers <=0 and rr_last<=NUM_Q-1.
//   Also at that edge, complete_en<=0; pushes and the grant of the flash cycle are discarded.
//   overflow is NOT cleared by flash. complete_en is 0 in the cycle after flash.
//   r_full reads 0 in the cycle after flash.
//  Reset asserted mid-operation clears all state immediately (asynchronously).
//   The first push accepted after reset rises is treated as on an idle block.
//  Results are never reordered within one producer; no ordering guarantee across producers.
// TESTING
//  T1 single: push ALU tag=0x05 data=0xDEADBEEF in cycle 10 -> cycle 12 complete_en=1, src=0, data matches; cycle 13 complete_en=0.
//  T2 all at once: all 5 ports push in cycle 10 (tags 0..4) -> cycles 12..16 emit src 0,1,2,3,4 in order; then complete_en=0.
//  T3 fairness: ports 0 and 3 push every cycle (r_full respected) -> output alternates src 0,3,0,3; no port starved >2 cycles.
//  T4 full: DEPTH=4, port 2 pushes 4x in cycles 10..13 while ports 0,1 keep the arbiter busy
//   -> r_full[2]=1 once 4 are held; a 5th push is dropped and sets overflow=1; drained tags emit in FIFO order.
//  T5 flash: fill FIFOs 0,1,4 with 2 entries each, pulse flash in cycle 20 -> cycle 21 complete_en=0, r_full=0;
//   nothing pre-flash is ever emitted; overflow unchanged; new push in cycle 21 emits in cycle 23.
//  T6 async reset: drop reset mid-cycle while 3 entries are queued -> complete_en=0 and overflow=0 immediately;
//   after release a push in cycle N emits in N+2 with src from rr_last=NUM_Q-1 ordering.

Source files
------------

// File: rtl/result_collector.sv
// result_collector: per-producer result FIFOs feeding a round-robin
// completion broadcast toward the commit queue and RS wakeup logic.
module result_collector #(
    parameter int NUM_Q    = 5,
    parameter int DEPTH    = 4,
    parameter int RESULT_W = 41
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flash,
    input  logic [NUM_Q-1:0]          r_en,
    input  logic [NUM_Q*RESULT_W-1:0] r_data,
    output logic [NUM_Q-1:0]          r_full,
    output logic                      complete_en,
    output logic [RESULT_W-1:0]       complete_data,
    output logic [$clog2(NUM_Q)-1:0]  complete_src,
    output logic                      overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int SW = $clog2(NUM_Q);

    logic [RESULT_W-1:0] mem [NUM_Q][DEPTH];
    logic [PW-1:0]       wr_ptr [NUM_Q];
    logic [PW-1:0]       rd_ptr [NUM_Q];
    logic [SW-1:0]       rr_last;
    logic [NUM_Q-1:0]    elig;
    logic [NUM_Q-1:0]    push;
    logic                gnt_vld;
    logic [SW-1:0]       gnt;
    logic [SW-1:0]       idx;

    always_comb begin
        r_full = '0;
        elig   = '0;
        for (int i = 0; i < NUM_Q; i++) begin
            r_full[i] = (wr_ptr[i] - rd_ptr[i]) == PW'(DEPTH);
            elig[i]   = wr_ptr[i] != rd_ptr[i];
        end
        push = r_en & ~r_full;
    end

    // Scan downward so the nearest index after rr_last wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = NUM_Q; k >= 1; k--) begin
            idx = SW'((int'(rr_last) + k) % NUM_Q);
            if (elig[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_Q; i++) begin
            if (push[i] && !flash)
                mem[i][wr_ptr[i][AW-1:0]] <= r_data[i*RESULT_W +: RESULT_W];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_Q; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
            rr_last       <= SW'(NUM_Q - 1);
            complete_en   <= 1'b0;
            complete_data <= '0;
            complete_src  <= '0;
            overflow      <= 1'b0;
        end else begin
            if (|(r_en & r_full))
                overflow <= 1'b1;
            if (flash) begin
                for (int i = 0; i < NUM_Q; i++) begin
                    wr_ptr[i] <= '0;
                    rd_ptr[i] <= '0;
                end
                rr_last     <= SW'(NUM_Q - 1);
                complete_en <= 1'b0;
            end else begin
                for (int i = 0; i < NUM_Q; i++) begin
                    if (push[i])
                        wr_ptr[i] <= wr_ptr[i] + PW'(1);
                end
                if (gnt_vld) begin
                    rd_ptr[gnt]   <= rd_ptr[gnt] + PW'(1);
                    rr_last       <= gnt;
                    complete_en   <= 1'b1;
                    complete_data <= mem[gnt][rd_ptr[gnt][AW-1:0]];
                    complete_src  <= gnt;
                end else begin
                    complete_en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector with a per-producer
// scoreboard checked whenever complete_en is seen.
module tb_result_collector;

    localparam int NQ = 5;
    localparam int RW = 41;

    logic             clock = 1'b0;
    logic             reset;
    logic             flash;
    logic [NQ-1:0]    r_en;
    logic [NQ*RW-1:0] r_data;
    logic [NQ-1:0]    r_full;
    logic             complete_en;
    logic [RW-1:0]    complete_data;
    logic [2:0]       complete_src;
    logic             overflow;

    always #5 clock = ~clock;

    result_collector #(
        .NUM_Q(NQ),
        .DEPTH(4),
        .RESULT_W(RW)
    ) dut (
        .clock(clock),
        .reset(reset),
        .flash(flash),
        .r_en(r_en),
        .r_data(r_data),
        .r_full(r_full),
        .complete_en(complete_en),
        .complete_data(complete_data),
        .complete_src(complete_src),
        .overflow(overflow)
    );

    int            nvec = 0;
    int            nerr = 0;
    logic [RW-1:0] exp_q [NQ][$];
    logic [2:0]    prev;
    bit            have_prev;
    logic          ov0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] expv);
        nvec++;
        assert (obs === expv) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [RW-1:0] res(input logic [7:0] tag,
                                          input logic [31:0] d);
        return {tag, d, 1'b1};
    endfunction

    function automatic int sb_left();
        int n = 0;
        for (int i = 0; i < NQ; i++) n += exp_q[i].size();
        return n;
    endfunction

    task automatic sb_clear();
        for (int i = 0; i < NQ; i++) exp_q[i].delete();
    endtask

    // A push is expected to land only if the FIFO is not full now.
    task automatic push(input int p, input logic [RW-1:0] v, input bit sb);
        if (sb && r_full[p] === 1'b0) exp_q[p].push_back(v);
        r_en[p] = 1'b1;
        r_data[p*RW +: RW] = v;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        r_en  = '0;
        flash = 1'b0;
        if (complete_en === 1'b1) begin
            if (complete_src >= NQ || exp_q[complete_src].size() == 0)
                chk("sb_unexpected_src", 64'(complete_src), 64'hFF);
            else
                chk("sb_data", 64'(complete_data),
                    64'(exp_q[complete_src].pop_front()));
        end
    endtask

    task automatic do_flash();
        flash = 1'b1;
        tick();
        sb_clear();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset  = 1'b1;
        flash  = 1'b0;
        r_en   = '0;
        r_data = '0;
        #2 reset = 1'b0;
        #1;
        chk("rst_en", 64'(complete_en), 0);
        chk("rst_data", 64'(complete_data), 0);
        chk("rst_src", 64'(complete_src), 0);
        chk("rst_ovf", 64'(overflow), 0);
        chk("rst_full", 64'(r_full), 0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;

        // T1: single ALU result, two-cycle latency
        push(0, res(8'h05, 32'hDEADBEEF), 1);
        tick();
        chk("t1_lat1", 64'(complete_en), 0);
        tick();
        chk("t1_en", 64'(complete_en), 1);
        chk("t1_src", 64'(complete_src), 0);
        chk("t1_data", 64'(complete_data), 64'(res(8'h05, 32'hDEADBEEF)));
        tick();
        chk("t1_idle", 64'(complete_en), 0);

        // T2: all ports at once from the post-flash pointer
        do_flash();
        for (int p = 0; p < NQ; p++)
            push(p, res(8'(p), $urandom), 1);
        tick();
        chk("t2_lat1", 64'(complete_en), 0);
        for (int k = 0; k < NQ; k++) begin
            tick();
            chk("t2_en", 64'(complete_en), 1);
            chk("t2_src", 64'(complete_src), 64'(k));
        end
        tick();
        chk("t2_idle", 64'(complete_en), 0);

        // T3: ports 0 and 3 stream continuously
        do_flash();
        have_prev = 1'b0;
        for (int c = 0; c < 24; c++) begin
            if (!r_full[0]) push(0, res(8'h30, 32'(c)), 1);
            if (!r_full[3]) push(3, res(8'h33, 32'(c)), 1);
            tick();
            if (complete_en === 1'b1) begin
                if (have_prev)
                    chk("t3_alt", 64'(complete_src != prev), 1);
                else
                    chk("t3_first", 64'(complete_src), 0);
                prev      = complete_src;
                have_prev = 1'b1;
            end
        end
        for (int c = 0; c < 40 && sb_left() > 0; c++) tick();
        chk("t3_drained", 64'(sb_left()), 0);

        // T4: fill port 2 while 0 and 1 compete, then overflow it
        do_flash();
        for (int c = 0; c < 20 && r_full[2] !== 1'b1; c++) begin
            if (!r_full[0]) push(0, res(8'h40, 32'(c)), 1);
            if (!r_full[1]) push(1, res(8'h41, 32'(c)), 1);
            push(2, res(8'h42, 32'(c)), 1);
            tick();
        end
        chk("t4_full", 64'(r_full[2]), 1);
        chk("t4_ovf_pre", 64'(overflow), 0);
        push(2, res(8'hEE, 32'hBAD0BAD0), 1);
        tick();
        chk("t4_ovf", 64'(overflow), 1);
        for (int c = 0; c < 60 && sb_left() > 0; c++) tick();
        chk("t4_drained", 64'(sb_left()), 0);
        tick();
        chk("t4_idle", 64'(complete_en), 0);

        // T5: flash with entries pending in 0, 1 and 4
        do_flash();
        for (int r = 0; r < 2; r++) begin
            push(0, res(8'h50, 32'(r)), 1);
            push(1, res(8'h51, 32'(r)), 1);
            push(4, res(8'h54, 32'(r)), 1);
            tick();
        end
        ov0   = overflow;
        flash = 1'b1;
        push(1, res(8'hF1, 32'hF1F1F1F1), 0);
        tick();
        sb_clear();
        chk("t5_en", 64'(complete_en), 0);
        chk("t5_full", 64'(r_full), 0);
        push(2, res(8'h21, 32'h12345678), 1);
        tick();
        chk("t5_lat1", 64'(complete_en), 0);
        tick();
        chk("t5_en2", 64'(complete_en), 1);
        chk("t5_src", 64'(complete_src), 2);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t5_quiet", 64'(complete_en), 0);
        end
        chk("t5_ovf_kept", 64'(overflow), 64'(ov0));

        // T6: asynchronous reset with three entries queued
        push(0, res(8'h60, 32'h0), 1);
        push(1, res(8'h61, 32'h1), 1);
        push(2, res(8'h62, 32'h2), 1);
        tick();
        #2 reset = 1'b0;
        #1;
        sb_clear();
        chk("t6_en", 64'(complete_en), 0);
        chk("t6_ovf", 64'(overflow), 0);
        chk("t6_full", 64'(r_full), 0);
        chk("t6_data", 64'(complete_data), 0);
        @(posedge clock);
        #3 reset = 1'b1;
        push(3, res(8'h73, 32'hCAFE0003), 1);
        push(1, res(8'h71, 32'hCAFE0001), 1);
        tick();
        chk("t6_lat1", 64'(complete_en), 0);
        tick();
        chk("t6_en_a", 64'(complete_en), 1);
        chk("t6_src_a", 64'(complete_src), 1);
        tick();
        chk("t6_en_b", 64'(complete_en), 1);
        chk("t6_src_b", 64'(complete_src), 3);
        tick();
        chk("t6_idle", 64'(complete_en), 0);

        chk("end_sb_empty", 64'(sb_left()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
